fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the program counter and the IF/ID instruction register of the pipelined MIPS core.
- Fetches from instruction memory over a req/ack handshake and holds the fetched word for the ID stage under hazard stalls.
- Applies branch/jump redirects produced by the next-PC logic in ID, with MIPS one-instruction delay-slot semantics.
- Sits between instruction memory, the hazard unit (stall) and the ID-stage next-PC block, which it feeds with pc4.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
CNT_W, 32, width of the retired-fetch debug counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hazard unit: 1 = ID stage frozen, IF/ID must hold
redirect_valid  input  1  one-cycle pulse: control transfer resolved in ID is taken
redirect_pc  input  32  target address (branch, j/jal or jr/jalr), valid with redirect_valid
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
if_valid  output  1  IF/ID register holds a valid instruction
if_instr  output  32  IF/ID instruction
if_pc  output  32  address of if_instr
if_pc4  output  32  if_pc + 4, drives the next-PC block
fetch_cnt  output  CNT_W  number of instructions consumed by ID

Behaviour:
- Reset values, applied immediately on reset low: state IDLE, imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc RESET_PC, if_pc4 RESET_PC+4, pending_valid 0, pending_pc 0, fetch_cnt 0.
- The block keeps at most one instruction beyond ID. A new fetch starts only after the IF/ID contents have been consumed.
- Consume is defined as state FULL and stall==0.
- FSM states:
  - IDLE: entered only by reset. On the first clock edge after reset release, go to REQ with imem_addr=RESET_PC.
  - REQ: imem_req=1. imem_addr stays stable until ack. On imem_ack (0-wait ack in the same cycle as the request is legal), register if_instr<=imem_rdata, if_pc<=imem_addr, if_pc4<=imem_addr+4, if_valid<=1, then go to FULL.
  - FULL: imem_req=0. If stall==1, hold all outputs. On consume: if_valid<=0, fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CNT_W), go to REQ with imem_addr<=next_addr.
- Address selection: next_addr = pending_valid ? pending_pc : if_pc4. Whenever pending_pc is used, pending_valid is cleared.
- redirect_valid is sampled only on a consume cycle and ignored at all other times.
- On a sampled redirect: pending_pc<=redirect_pc, pending_valid<=1. The fetch issued in that same cycle is the delay slot (if_pc4, or the old pending target). The following fetch goes to redirect_pc.
- Simultaneous consume with pending_valid=1 and redirect_valid=1 (branch in a delay slot): next_addr uses the old pending_pc. The pending register is then loaded with the new redirect_pc and stays valid.
- All address arithmetic is 32-bit and wraps at 2^32 (32'hFFFF_FFFC+4 = 0). imem_addr[1:0] is always 0; redirect_pc[1:0] is forced to 0.
- Reset mid-fetch: imem_req drops asynchronously. An imem_ack arriving while reset is asserted, or in IDLE, is ignored.
- imem_ack outside REQ is ignored.
- Latency: reset release to first imem_req = 1 cycle. With zero-wait memory and no stall, throughput is one instruction per 2 cycles.

Test Plan:
1. Reset release, 0-wait ack, stall=0, memory returns the address as data -> imem_addr sequence 0x3000, 0x3004, 0x3008. if_valid high every other cycle. fetch_cnt=3 after three consumes.
2. Hold imem_ack low 3 cycles at 0x3004 -> imem_req and imem_addr=0x3004 stable all 3 cycles. if_instr updates only on ack. No extra request is issued.
3. stall=1 for 4 cycles with if_pc=0x3008 -> if_instr, if_pc and if_valid constant. imem_req=0. fetch_cnt unchanged. First request after release is 0x300C.
4. Consume a branch at if_pc=0x3010 with redirect_valid=1, redirect_pc=0x3100 -> next fetches 0x3014 (delay slot), then 0x3100, 0x3104.
5. Redirect at 0x3010 to 0x3100; the delay slot at 0x3014 also redirects to 0x3200 -> fetch order 0x3014, 0x3100, 0x3200.
6. Assert reset during REQ at 0x3020 with ack pulsing while reset is low -> imem_req=0 immediately, all outputs at reset values. After release, the first fetch is 0x3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and IF/ID register of a pipelined MIPS core
//
// Fetches one instruction at a time over a req/ack handshake. It holds the
// fetched word in IF/ID until ID consumes it (FULL and !stall). It applies ID
// redirects with a one-instruction delay slot.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   stall          hazard unit: ID frozen, IF/ID holds
//   redirect_valid taken control transfer from ID, sampled only on consume
//   redirect_pc    redirect target, low two bits ignored
//   imem_req       fetch request
//   imem_addr      fetch address, word aligned, stable until ack
//   imem_ack       fetch complete, imem_rdata valid
//   imem_rdata     fetched instruction
//   if_valid       IF/ID holds a valid instruction
//   if_instr       IF/ID instruction
//   if_pc          address of if_instr
//   if_pc4         if_pc + 4, for the next-PC block
//   fetch_cnt      instructions consumed by ID, wrapping
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc4,
    output logic [CNT_W-1:0] fetch_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

    state_t      state, state_next;
    logic        pending_valid;
    logic [31:0] pending_pc;
    logic        consume;
    logic        fetch_done;
    logic [31:0] next_addr;
    logic [31:0] target;

    // A pending target always wins over sequential flow; it is the branch
    // whose delay slot has just been fetched.
    assign next_addr = pending_valid ? pending_pc : if_pc4;
    assign target    = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // imem_req decodes the state alone, so it drops as soon as reset is asserted.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        consume    = 1'b0;
        fetch_done = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr     <= RESET_PC;
            if_valid      <= 1'b0;
            if_instr      <= 32'h0;
            if_pc         <= RESET_PC;
            if_pc4        <= RESET_PC + 32'd4;
            pending_valid <= 1'b0;
            pending_pc    <= 32'h0;
            fetch_cnt     <= '0;
        end else begin
            if (fetch_done) begin
                if_instr <= imem_rdata;
                if_pc    <= imem_addr;
                if_pc4   <= imem_addr + 32'd4;
                if_valid <= 1'b1;
            end
            if (consume) begin
                if_valid      <= 1'b0;
                fetch_cnt     <= fetch_cnt + CNT_W'(1);
                imem_addr     <= next_addr;
                // A redirect in a delay slot re-arms pending after the old
                // target has been used. Otherwise any used target is retired.
                pending_valid <= redirect_valid;
                if (redirect_valid) begin
                    pending_pc <= target;
                end
            end
        end
    end
endmodule
